// File: rtl/alu_pipe.sv
// alu_pipe: registered execute-stage ALU with valid/ready handshakes on both
// sides and registered result/flags. Optional multiply FSM behind ALU_MUL_EN.
// Ports: clk, rst (sync, active-high); in_valid/in_ready, func[3:0], ain, bin;
//   out_valid/out_ready, result, carry, z, neg, ovf, illegal, busy.
// ALU_MUL_EN defined: opcode 1101 runs a WIDTH-step shift-add multiply.
// ALU_MUL_EN undefined: 1101 completes in one clock and reports illegal.
module alu_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       func,
  input  logic [WIDTH-1:0] ain,
  input  logic [WIDTH-1:0] bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             z,
  output logic             neg,
  output logic             ovf,
  output logic             illegal,
  output logic             busy
);

  localparam int M = WIDTH - 1;
  localparam logic [3:0] OP_MUL = 4'b1101;

  logic [WIDTH:0] ea, eb;
  logic [WIDTH:0] add_r, sub_r, rsub_r;
  logic [WIDTH:0] inc_r, dec_r;

  assign ea     = {1'b0, ain};
  assign eb     = {1'b0, bin};
  assign add_r  = ea + eb;
  assign sub_r  = ea - eb;
  assign rsub_r = eb - ea;
  assign inc_r  = ea + (WIDTH+1)'(1);
  assign dec_r  = ea - (WIDTH+1)'(1);

  function automatic logic
    ovf_add(logic a, logic b, logic r);
    return (a == b) && (r != a);
  endfunction

  function automatic logic
    ovf_sub(logic a, logic b, logic r);
    return (a != b) && (r != a);
  endfunction

  logic [WIDTH-1:0] nres;
  logic             ncar;
  logic             novf;
  logic             nill;

  always_comb begin
    nres = '0;
    ncar = 1'b0;
    novf = 1'b0;
    nill = 1'b0;
    case (func)
      4'b0000: nres = ~(ain & bin);
      4'b0001: begin
        nres = add_r[M:0];
        ncar = add_r[WIDTH];
        novf = ovf_add(ain[M], bin[M], add_r[M]);
      end
      4'b0010: begin
        nres = sub_r[M:0];
        ncar = sub_r[WIDTH];
        novf = ovf_sub(ain[M], bin[M], sub_r[M]);
      end
      4'b0011: begin
        nres = inc_r[M:0];
        ncar = inc_r[WIDTH];
        novf = ovf_add(ain[M], 1'b0, inc_r[M]);
      end
      4'b0100: begin
        nres = dec_r[M:0];
        ncar = dec_r[WIDTH];
        novf = ovf_sub(ain[M], 1'b0, dec_r[M]);
      end
      4'b0101: nres = add_r[M:0];
      4'b0110: nres = sub_r[M:0];
      4'b0111: nres = ain ^ bin;
      4'b1000: nres = ~ain;
      // Equal operands xor to zero, so z reports equality.
      4'b1001: nres = ain ^ bin;
      4'b1010, 4'b1011: begin
        nres = sub_r[M:0];
        ncar = sub_r[WIDTH];
        novf = ovf_sub(ain[M], bin[M], sub_r[M]);
      end
      4'b1100: begin
        nres = rsub_r[M:0];
        ncar = rsub_r[WIDTH];
        novf = ovf_sub(bin[M], ain[M], rsub_r[M]);
      end
      4'b1101: begin
`ifndef ALU_MUL_EN
        nill = 1'b1;
`else
        nres = '0;
`endif
      end
      4'b1110, 4'b1111: nres = add_r[M:0];
    endcase
  end

  assign z   = (result == '0);
  assign neg = result[M];

  logic accept;
  assign accept = in_valid && in_ready;

`ifdef ALU_MUL_EN
  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    HOLD
  } state_t;

  state_t               state;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0]   acc_nx;
  logic [WIDTH-1:0]     mplier;
  logic [CNT_W-1:0]     cnt;
  logic                 last;

  assign acc_nx = mplier[0] ? acc + mcand : acc;
  assign last   = (cnt == CNT_W'(WIDTH - 1));

  assign in_ready = !rst && (state == IDLE)
                 && (!out_valid || out_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      carry     <= 1'b0;
      ovf       <= 1'b0;
      illegal   <= 1'b0;
      busy      <= 1'b0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      cnt       <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept && func == OP_MUL) begin
            state     <= MUL;
            busy      <= 1'b1;
            out_valid <= 1'b0;
            acc       <= '0;
            mcand     <= {{WIDTH{1'b0}}, ain};
            mplier    <= bin;
            cnt       <= '0;
          end else if (accept) begin
            out_valid <= 1'b1;
            result    <= nres;
            carry     <= ncar;
            ovf       <= novf;
            illegal   <= nill;
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        MUL: begin
          acc    <= acc_nx;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CNT_W'(1);
          if (last) begin
            result    <= acc_nx[WIDTH-1:0];
            carry     <= |acc_nx[2*WIDTH-1:WIDTH];
            ovf       <= 1'b0;
            illegal   <= 1'b0;
            out_valid <= 1'b1;
            busy      <= 1'b0;
            state     <= out_ready ? IDLE : HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  assign busy     = 1'b0;
  assign in_ready = !rst && (!out_valid || out_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      carry     <= 1'b0;
      ovf       <= 1'b0;
      illegal   <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      result    <= nres;
      carry     <= ncar;
      ovf       <= novf;
      illegal   <= nill;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed vector table plus handshake,
// hold and multiply corner sequences for alu_pipe (WIDTH=8).
module tb_alu_pipe;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   func;
  logic [W-1:0] ain;
  logic [W-1:0] bin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         carry;
  logic         z;
  logic         neg;
  logic         ovf;
  logic         illegal;
  logic         busy;

  alu_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .func      (func),
    .ain       (ain),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry     (carry),
    .z         (z),
    .neg       (neg),
    .ovf       (ovf),
    .illegal   (illegal),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h",
               nm, got, exp);
    end
  endtask

  typedef struct {
    logic [3:0]   f;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] r;
    logic         c;
    logic         o;
    logic         il;
  } vec_t;

  vec_t tv[$];

  function automatic void addv(logic [3:0] f,
                               logic [W-1:0] a,
                               logic [W-1:0] b,
                               logic [W-1:0] r,
                               logic c, logic o,
                               logic il);
    vec_t v;
    v.f = f; v.a = a; v.b = b; v.r = r;
    v.c = c; v.o = o; v.il = il;
    tv.push_back(v);
  endfunction

  task automatic wait_out(input int lim,
                          output bit ok);
    ok = 1'b0;
    for (int k = 0; k < lim; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  logic [14:0] got_v, exp_v;
  bit ok;
  bit pulsed;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    func = 4'h0; ain = '0; bin = '0;

    //          f      a      b      r     c  o  il
    addv(4'b0001, 8'hff, 8'h01, 8'h00, 1, 0, 0);
    addv(4'b0010, 8'h05, 8'h07, 8'hfe, 1, 0, 0);
    addv(4'b0001, 8'h7f, 8'h01, 8'h80, 0, 1, 0);
    addv(4'b0000, 8'hf0, 8'h3c, 8'hcf, 0, 0, 0);
    addv(4'b0011, 8'h7f, 8'h55, 8'h80, 0, 1, 0);
    addv(4'b0100, 8'h00, 8'h55, 8'hff, 1, 0, 0);
    addv(4'b0100, 8'h80, 8'h00, 8'h7f, 0, 1, 0);
    addv(4'b0101, 8'h7f, 8'h01, 8'h80, 0, 0, 0);
    addv(4'b0110, 8'h03, 8'h05, 8'hfe, 0, 0, 0);
    addv(4'b0111, 8'ha5, 8'h5a, 8'hff, 0, 0, 0);
    addv(4'b1000, 8'h0f, 8'hff, 8'hf0, 0, 0, 0);
    addv(4'b1001, 8'h33, 8'h33, 8'h00, 0, 0, 0);
    addv(4'b1001, 8'h33, 8'h30, 8'h03, 0, 0, 0);
    addv(4'b1010, 8'h80, 8'h01, 8'h7f, 0, 1, 0);
    addv(4'b1011, 8'h02, 8'h03, 8'hff, 1, 0, 0);
    addv(4'b1100, 8'h05, 8'h03, 8'hfe, 1, 0, 0);
    addv(4'b1100, 8'h01, 8'h80, 8'h7f, 0, 1, 0);
    addv(4'b1110, 8'h10, 8'h20, 8'h30, 0, 0, 0);
    addv(4'b1111, 8'hf0, 8'h20, 8'h10, 0, 0, 0);
`ifndef ALU_MUL_EN
    addv(4'b1101, 8'h03, 8'h04, 8'h00, 0, 0, 1);
`endif
    addv(4'b0001, 8'h01, 8'h01, 8'h02, 0, 0, 0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_regs",
        {out_valid, result, carry, neg,
         ovf, illegal, busy}, 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 32'(in_ready), 32'd1);

    // Back-to-back stream, one op per clock.
    foreach (tv[i]) begin
      @(negedge clk);
      func = tv[i].f; ain = tv[i].a; bin = tv[i].b;
      in_valid = 1'b1;
      #1;
      chk($sformatf("v%0d_in_ready", i),
          32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      got_v = {out_valid, result, carry, z, neg,
               ovf, illegal, busy};
      exp_v = {1'b1, tv[i].r, tv[i].c,
               tv[i].r == 8'h00, tv[i].r[W-1],
               tv[i].o, tv[i].il, 1'b0};
      chk($sformatf("v%0d_f%b", i, tv[i].f),
          32'(got_v), 32'(exp_v));
    end

    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("drain", {out_valid, result},
        {1'b0, 8'h02});

    // Stall: output held for 3 clocks.
    @(negedge clk);
    func = 4'b0001; ain = 8'h10; bin = 8'h20;
    in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("hold_load", {out_valid, result},
        {1'b1, 8'h30});
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      func = 4'b0111; ain = 8'h3c + 8'(k);
      bin = 8'h0f;
      #1;
      chk($sformatf("hold%0d_ready", k),
          32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      chk($sformatf("hold%0d_res", k),
          {out_valid, result}, {1'b1, 8'h30});
    end
    @(negedge clk);
    out_ready = 1'b1; ain = 8'hf0; bin = 8'h0f;
    #1;
    chk("release_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    chk("release_xor",
        {out_valid, result, neg}, {1'b1, 8'hff, 1'b1});
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("release_drain", {out_valid, result},
        {1'b0, 8'hff});

`ifdef ALU_MUL_EN
    // MUL 0c*0d: busy 8 clocks, result at clock 9.
    @(negedge clk);
    func = 4'b1101; ain = 8'h0c; bin = 8'h0d;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    chk("mul_accept", {busy, out_valid, in_ready},
        3'b100);
    @(negedge clk);
    in_valid = 1'b0; ain = 8'hff; bin = 8'hff;
    for (int k = 0; k < 7; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("mul_busy%0d", k),
          {busy, out_valid}, 2'b10);
    end
    @(posedge clk);
    #1;
    chk("mul_0c0d",
        {out_valid, busy, result, carry, z, ovf},
        {1'b1, 1'b0, 8'h9c, 1'b0, 1'b0, 1'b0});
    @(posedge clk);
    #1;
    chk("mul_drain", 32'(out_valid), 32'd0);

    // MUL 10*10 with consumer stalled.
    @(negedge clk);
    func = 4'b1101; ain = 8'h10; bin = 8'h10;
    in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    wait_out(12, ok);
    chk("mul_timeout", 32'(ok), 32'd1);
    chk("mul_1010", {result, carry, z},
        {8'h00, 1'b1, 1'b1});
    @(negedge clk);
    chk("mul_hold_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("mul_hold", {out_valid, result, carry},
        {1'b1, 8'h00, 1'b1});
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("mul_hold_rel", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("mul_idle_ready", 32'(in_ready), 32'd1);

    // Reset during the third multiply clock.
    func = 4'b1101; ain = 8'h05; bin = 8'h05;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mul_rst", {out_valid, busy}, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mul_rst_ready", 32'(in_ready), 32'd1);
    pulsed = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      if (out_valid || busy) pulsed = 1'b1;
    end
    chk("mul_rst_nopulse", 32'(pulsed), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
